csm_ctrl: RTL and testbench

- Shared-memory controller that consumes the processor A/B bus driven by the CSM bus-functional model.
- Decodes each port's multiplexed address/data protocol: read, two-cycle write, hold (lock) and release.
- Arbitrates both ports onto one single-port memory of 2**DATABITS words and returns ack, error and read data per port.

---
 rtl/csm_ctrl_if.sv | 38 +++
 rtl/csm_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_csm_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csm_ctrl_if.sv
// csm_ctrl_if: one processor port of the CSM shared-memory bus.
//
// The bus-functional model (master) drives a command strobe with a
// multiplexed address/data word plus lock controls. The controller (slave)
// answers with ack, a completion status and read data.
//
// Signals:
//   in_ad       master->slave  DATABITS  address (first cycle) / write data (second cycle)
//   rw          master->slave  1         1 = write, 0 = read
//   enable      master->slave  1         command strobe, sampled on posedge
//   hold        master->slave  1         lock request
//   release_req master->slave  1         lock release ('release' is a reserved word)
//   ack         slave->master  1         1 = port idle / command complete
//   err         slave->master  ERRBITS   completion status
//   out_data    slave->master  DATABITS  read data
interface csm_ctrl_if #(
    parameter int DATABITS = 8,
    parameter int ERRBITS  = 2
) ();
    logic [DATABITS-1:0] in_ad;
    logic                rw;
    logic                enable;
    logic                hold;
    logic                release_req;
    logic                ack;
    logic [ERRBITS-1:0]  err;
    logic [DATABITS-1:0] out_data;

    modport master (
        output in_ad, rw, enable, hold, release_req,
        input  ack, err, out_data
    );

    modport slave (
        input  in_ad, rw, enable, hold, release_req,
        output ack, err, out_data
    );
endinterface

// File: rtl/csm_ctrl.sv
// csm_ctrl: dual-port shared-memory controller for the CSM processor bus.
//
// Each port runs its own small command FSM that decodes the multiplexed
// address/data protocol (read, two-cycle write, hold, release). Both ports
// share one single-port memory of 2**DATABITS words; a round-robin arbiter
// grants at most one access per cycle. A lock (hold/release) lets one port
// keep the other away from the memory; a blocked access completes at once
// with the "locked" status.
//
// Ports:
//   clk    input   system clock, all logic on posedge
//   reset  input   synchronous, active-high reset
//   a_bus  slave   port A (see csm_ctrl_if)
//   b_bus  slave   port B
//
// Error codes: 00 ok, 01 locked by other port, 10 release by non-owner,
//              11 protocol error.
//
// Per-port states:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | ack=1, waiting for enable; hold/release resolved here
//   ST_WDATA | write address latched, expecting data with enable=1
//   ST_RD    | read pending, requesting the memory
//   ST_WR    | write pending (address and data latched), requesting memory
module csm_ctrl #(
    parameter int DATABITS = 8,
    parameter int ERRBITS  = 2
) (
    input logic       clk,
    input logic       reset,
    csm_ctrl_if.slave a_bus,
    csm_ctrl_if.slave b_bus
);

    localparam int MEM_WORDS = 2 ** DATABITS;

    localparam logic [ERRBITS-1:0] ERR_OK     = ERRBITS'(0);
    localparam logic [ERRBITS-1:0] ERR_LOCKED = ERRBITS'(1);
    localparam logic [ERRBITS-1:0] ERR_OWNER  = ERRBITS'(2);
    localparam logic [ERRBITS-1:0] ERR_PROTO  = ERRBITS'(3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_A    = 2'd1,
        LK_B    = 2'd2
    } lock_t;

    function automatic lock_t own_lock(input int p);
        return (p == 0) ? LK_A : LK_B;
    endfunction

    // ------------------------------------------------------------------
    // Port inputs gathered into per-port vectors (index 0 = A, 1 = B)
    // ------------------------------------------------------------------
    logic [1:0]          en;
    logic [1:0]          rw;
    logic [1:0]          hold;
    logic [1:0]          rel;
    logic [DATABITS-1:0] in_ad [2];

    assign en       = {b_bus.enable,      a_bus.enable};
    assign rw       = {b_bus.rw,          a_bus.rw};
    assign hold     = {b_bus.hold,        a_bus.hold};
    assign rel      = {b_bus.release_req, a_bus.release_req};
    assign in_ad[0] = a_bus.in_ad;
    assign in_ad[1] = b_bus.in_ad;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q [2];
    state_t              state_d [2];
    logic [DATABITS-1:0] addr_q  [2];
    logic [DATABITS-1:0] addr_d  [2];
    logic [DATABITS-1:0] data_q  [2];
    logic [DATABITS-1:0] data_d  [2];
    logic [1:0]          ack_q;
    logic [1:0]          ack_d;
    logic [ERRBITS-1:0]  err_q   [2];
    logic [ERRBITS-1:0]  err_d   [2];
    logic [DATABITS-1:0] out_q   [2];
    logic [DATABITS-1:0] out_d   [2];
    lock_t               lock_q;
    lock_t               lock_d;
    lock_t               lock_mid;
    logic                rr_last_q;   // last granted port: 0 = A, 1 = B
    logic                rr_last_d;
    logic [DATABITS-1:0] mem_q   [MEM_WORDS];
    logic [DATABITS-1:0] mem_d   [MEM_WORDS];

    // ------------------------------------------------------------------
    // Per-port command decode and memory request
    // ------------------------------------------------------------------
    logic [1:0] hold_cmd;
    logic [1:0] rel_cmd;
    logic [1:0] other_owns;
    logic [1:0] req;
    logic [1:0] grant;

    for (genvar g = 0; g < 2; g++) begin : g_dec
        assign hold_cmd[g]   = (state_q[g] == ST_IDLE) & en[g] & hold[g] & ~rel[g];
        assign rel_cmd[g]    = (state_q[g] == ST_IDLE) & en[g] & rel[g]  & ~hold[g];
        assign other_owns[g] = (lock_q == own_lock(1 - g));
        assign req[g]        = ((state_q[g] == ST_RD) || (state_q[g] == ST_WR)) & ~other_owns[g];
    end

    // ------------------------------------------------------------------
    // Arbiter. A port whose peer owns the lock never requests, so two
    // simultaneous requests imply the lock is free and plain round robin
    // decides: the port that was not granted last wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant     = req;
        rr_last_d = rr_last_q;
        if (req == 2'b11) begin
            grant = rr_last_q ? 2'b01 : 2'b10;
        end
        if (grant[0]) begin
            rr_last_d = 1'b0;
        end else if (grant[1]) begin
            rr_last_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lock resolution. Releases apply before holds so a release by the
    // owner and a hold by the other port at the same edge hand the lock
    // over. Two holds against a free lock use the round-robin pointer as
    // tie-break without moving it.
    // ------------------------------------------------------------------
    always_comb begin
        lock_mid = lock_q;
        for (int i = 0; i < 2; i++) begin
            if (rel_cmd[i] && (lock_q == own_lock(i))) begin
                lock_mid = LK_NONE;
            end
        end

        lock_d = lock_mid;
        if ((hold_cmd == 2'b11) && (lock_mid == LK_NONE)) begin
            lock_d = rr_last_q ? LK_A : LK_B;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (hold_cmd[i] && ((lock_mid == LK_NONE) || (lock_mid == own_lock(i)))) begin
                    lock_d = own_lock(i);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Port FSMs: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
            data_d[i]  = data_q[i];
            ack_d[i]   = ack_q[i];
            err_d[i]   = err_q[i];
            out_d[i]   = out_q[i];

            case (state_q[i])
                ST_IDLE: begin
                    if (en[i]) begin
                        if (hold[i] && rel[i]) begin
                            err_d[i] = ERR_PROTO;
                        end else if (hold[i]) begin
                            err_d[i] = (lock_d == own_lock(i)) ? ERR_OK : ERR_LOCKED;
                        end else if (rel[i]) begin
                            err_d[i] = (lock_q == own_lock(i)) ? ERR_OK : ERR_OWNER;
                        end else begin
                            addr_d[i]  = in_ad[i];
                            ack_d[i]   = 1'b0;
                            state_d[i] = rw[i] ? ST_WDATA : ST_RD;
                        end
                    end
                end

                ST_WDATA: begin
                    if (en[i]) begin
                        data_d[i]  = in_ad[i];
                        state_d[i] = ST_WR;
                    end else begin
                        err_d[i]   = ERR_PROTO;
                        ack_d[i]   = 1'b1;
                        state_d[i] = ST_IDLE;
                    end
                end

                ST_RD, ST_WR: begin
                    // enable is ignored here; the port only waits for the memory
                    if (other_owns[i]) begin
                        err_d[i]   = ERR_LOCKED;
                        ack_d[i]   = 1'b1;
                        state_d[i] = ST_IDLE;
                    end else if (grant[i]) begin
                        if (state_q[i] == ST_RD) begin
                            out_d[i] = mem_q[addr_q[i]];
                        end else begin
                            mem_d[addr_q[i]] = data_q[i];
                        end
                        err_d[i]   = ERR_OK;
                        ack_d[i]   = 1'b1;
                        state_d[i] = ST_IDLE;
                    end
                end

                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_IDLE;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                err_q[i]   <= ERR_OK;
                out_q[i]   <= '0;
            end
            ack_q     <= 2'b11;
            lock_q    <= LK_NONE;
            rr_last_q <= 1'b1;
            for (int w = 0; w < MEM_WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            out_q     <= out_d;
            lock_q    <= lock_d;
            rr_last_q <= rr_last_d;
            mem_q     <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_bus.ack      = ack_q[0];
    assign a_bus.err      = err_q[0];
    assign a_bus.out_data = out_q[0];
    assign b_bus.ack      = ack_q[1];
    assign b_bus.err      = err_q[1];
    assign b_bus.out_data = out_q[1];

endmodule

// File: tb/tb_csm_ctrl.sv
// tb_csm_ctrl: scoreboard bench for csm_ctrl.
// Stimulus tasks compute the expected completion from a transaction-level
// model (memory array, lock owner, last read value per port) and push it
// into a per-port queue; a monitor pops and compares whenever a port shows
// ack=1 after a command was issued.
module tb_csm_ctrl;

    localparam int DB = 8;
    localparam int EB = 2;

    localparam int K_RD    = 0;
    localparam int K_WR    = 1;
    localparam int K_HOLD  = 2;
    localparam int K_REL   = 3;
    localparam int K_PROTO = 4;

    typedef struct {
        logic [1:0] err;
        logic [7:0] data;
        int         issue_cyc;
        int         exp_cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    csm_ctrl_if #(.DATABITS(DB), .ERRBITS(EB)) a_if ();
    csm_ctrl_if #(.DATABITS(DB), .ERRBITS(EB)) b_if ();

    csm_ctrl #(.DATABITS(DB), .ERRBITS(EB)) dut (
        .clk   (clk),
        .reset (reset),
        .a_bus (a_if),
        .b_bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [7:0] m [256];
    int         lock_own;       // -1 none, 0 A, 1 B
    logic [7:0] last_out [2];

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;

    function automatic void model_reset();
        foreach (m[i]) m[i] = 8'h00;
        lock_own    = -1;
        last_out[0] = 8'h00;
        last_out[1] = 8'h00;
    endfunction

    function automatic int qsize(input int p);
        return (p == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare(input int p, input exp_t e, input logic [1:0] err, input logic [7:0] d);
        string pn;
        pn = (p == 0) ? "A" : "B";
        check({pn, "_err"}, int'(err), int'(e.err));
        check({pn, "_out_data"}, int'(d), int'(e.data));
        if (e.exp_cyc >= 0) check({pn, "_done_cycle"}, cyc, e.exp_cyc);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (q_a.size() != 0 && cyc >= q_a[0].issue_cyc && a_if.ack) begin
                ea = q_a.pop_front();
                compare(0, ea, a_if.err, a_if.out_data);
            end
            if (q_b.size() != 0 && cyc >= q_b[0].issue_cyc && b_if.ack) begin
                eb = q_b.pop_front();
                compare(1, eb, b_if.err, b_if.out_data);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input int p, input logic en, input logic rw, input logic hd,
                         input logic rl, input logic [7:0] ad);
        if (p == 0) begin
            a_if.enable = en; a_if.rw = rw; a_if.hold = hd; a_if.release_req = rl; a_if.in_ad = ad;
        end else begin
            b_if.enable = en; b_if.rw = rw; b_if.hold = hd; b_if.release_req = rl; b_if.in_ad = ad;
        end
    endtask

    task automatic wait_idle(input int p);
        int n;
        n = 0;
        while (qsize(p) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (qsize(p) != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL port%0d_timeout: no completion within 60 cycles, expected ack=1", p);
            if (p == 0) q_a.delete(); else q_b.delete();
        end
    endtask

    // extra: added cycles from lost contests (-1 = latency not checked)
    // forced: expected err supplied by caller, model untouched (-1 = use model)
    task automatic op(input int p, input int kind, input logic [7:0] addr, input logic [7:0] data,
                      input bit abort, input int extra, input int forced);
        exp_t e;
        int   lat;
        @(negedge clk);
        e.issue_cyc = cyc + 1;
        e.err       = 2'b00;
        lat         = 0;
        if (kind == K_RD) lat = 1;
        if (kind == K_WR) lat = abort ? 1 : 2;
        if (forced >= 0) begin
            e.err = 2'(forced);
        end else begin
            case (kind)
                K_RD:    if (lock_own == 1 - p) e.err = 2'b01; else last_out[p] = m[addr];
                K_WR:    if (abort) e.err = 2'b11;
                         else if (lock_own == 1 - p) e.err = 2'b01;
                         else m[addr] = data;
                K_HOLD:  if (lock_own == -1 || lock_own == p) lock_own = p; else e.err = 2'b01;
                K_REL:   if (lock_own == p) lock_own = -1; else e.err = 2'b10;
                default: e.err = 2'b11;
            endcase
        end
        e.data    = last_out[p];
        e.exp_cyc = (extra < 0) ? -1 : e.issue_cyc + lat + extra;
        drive(p, 1'b1, kind == K_WR, kind == K_HOLD || kind == K_PROTO,
              kind == K_REL || kind == K_PROTO, addr);
        if (p == 0) q_a.push_back(e); else q_b.push_back(e);
        @(negedge clk);
        if (kind == K_RD) begin
            // strobes while the read is pending must be ignored
            drive(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom));
            @(negedge clk);
        end else if (kind == K_WR) begin
            drive(p, !abort, 1'b0, 1'b0, 1'b0, data);
            @(negedge clk);
        end
        drive(p, 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
        wait_idle(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        q_a.delete();
        q_b.delete();
        model_reset();
        reset = 1'b0;
    endtask

    task automatic conc_port(input int p, input int n);
        int r;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            op(p, (r < 5) ? K_RD : K_WR, 8'(p * 128 + $urandom_range(0, 7)), 8'($urandom),
               r == 9, -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int r;
        int rp;
        int rk;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 0, 8'h00);
        model_reset();
        repeat (3) @(negedge clk);
        check("A_ack_reset", int'(a_if.ack), 1);
        check("A_err_reset", int'(a_if.err), 0);
        check("A_out_reset", int'(a_if.out_data), 0);
        check("B_ack_reset", int'(b_if.ack), 1);
        check("B_err_reset", int'(b_if.err), 0);
        check("B_out_reset", int'(b_if.out_data), 0);
        reset = 1'b0;

        // write then read back
        op(0, K_WR, 8'h10, 8'h5A, 0, 0, -1);
        op(0, K_RD, 8'h10, 8'h00, 0, 0, -1);

        // contention: after reset A wins, then round robin favours B
        do_reset();
        fork
            op(0, K_RD, 8'h01, 8'h00, 0, 0, -1);
            op(1, K_RD, 8'h02, 8'h00, 0, 1, -1);
        join
        op(1, K_WR, 8'h02, 8'h22, 0, 0, -1);
        op(0, K_WR, 8'h01, 8'h11, 0, 0, -1);
        fork
            op(0, K_RD, 8'h02, 8'h00, 0, 1, -1);
            op(1, K_RD, 8'h01, 8'h00, 0, 0, -1);
        join

        // lock scenario
        op(0, K_HOLD, 8'h00, 8'h00, 0, 0, -1);
        op(1, K_WR,   8'h20, 8'h33, 0, 0, -1);
        op(1, K_RD,   8'h20, 8'h00, 0, 0, -1);
        op(0, K_RD,   8'h20, 8'h00, 0, 0, -1);
        op(0, K_WR,   8'h20, 8'h44, 0, 0, -1);
        op(1, K_REL,  8'h00, 8'h00, 0, 0, -1);
        op(0, K_REL,  8'h00, 8'h00, 0, 0, -1);
        op(1, K_WR,   8'h20, 8'h55, 0, 0, -1);
        op(1, K_RD,   8'h20, 8'h00, 0, 0, -1);

        // protocol errors
        op(0, K_PROTO, 8'h00, 8'h00, 0, 0, -1);
        op(0, K_WR,    8'h21, 8'h99, 1, 0, -1);
        op(0, K_RD,    8'h21, 8'h00, 0, 0, -1);

        // reset during the write data cycle
        op(0, K_WR,    8'h31, 8'hC3, 0, 0, -1);
        op(0, K_RD,    8'h31, 8'h00, 0, 0, -1);
        op(0, K_PROTO, 8'h00, 8'h00, 0, 0, -1);
        @(negedge clk);
        drive(0, 1, 1, 0, 0, 8'h30);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 8'h77);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 8'h00);
        model_reset();
        check("A_ack_after_reset", int'(a_if.ack), 1);
        check("A_err_after_reset", int'(a_if.err), 0);
        check("A_out_after_reset", int'(a_if.out_data), 0);
        op(0, K_RD, 8'h30, 8'h00, 0, 0, -1);

        // simultaneous holds, then release/hold handover at one edge
        do_reset();
        fork
            op(0, K_HOLD, 8'h00, 8'h00, 0, 0, 0);
            op(1, K_HOLD, 8'h00, 8'h00, 0, 0, 1);
        join
        lock_own = 0;
        fork
            op(0, K_REL,  8'h00, 8'h00, 0, 0, 0);
            op(1, K_HOLD, 8'h00, 8'h00, 0, 0, 0);
        join
        lock_own = 1;
        op(0, K_WR,  8'h40, 8'h12, 0, 0, -1);
        op(1, K_REL, 8'h00, 8'h00, 0, 0, -1);

        // serial random traffic, all commands
        for (int k = 0; k < 250; k++) begin
            rp = $urandom_range(0, 1);
            r  = $urandom_range(0, 99);
            rk = (r < 35) ? K_RD : (r < 70) ? K_WR : (r < 82) ? K_HOLD : (r < 94) ? K_REL : K_PROTO;
            op(rp, rk, 8'(8'h40 + $urandom_range(0, 7)), 8'($urandom),
               (rk == K_WR) && ($urandom_range(0, 9) == 0), 0, -1);
        end

        // concurrent random traffic on disjoint address halves
        do_reset();
        fork
            conc_port(0, 60);
            conc_port(1, 60);
        join

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
